debug_ocimem_arbiter: RTL and testbench

DEBUG_OCIMEM_ARBITER -- requirements
Module: debug_ocimem_arbiter

---
 rtl/debug_ocimem_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_debug_ocimem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_ocimem_arbiter.sv
// Arbiter sharing one single-port debug RAM between a JTAG command port and an
// Avalon slave port; round-robin on ties, one access in flight at a time.
module debug_ocimem_arbiter #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              jtag_ld_addr,
    input  logic [ADDR_W-1:0] jtag_addr_in,
    input  logic              jtag_rd,
    input  logic              jtag_wr,
    input  logic [31:0]       jtag_wdata,
    output logic [31:0]       jtag_rdata,
    output logic              jtag_done,
    output logic              jtag_overrun,
    input  logic              jtag_clr_overrun,
    input  logic [ADDR_W-1:0] av_address,
    input  logic              av_read,
    input  logic              av_write,
    input  logic [31:0]       av_writedata,
    input  logic [3:0]        av_byteenable,
    output logic [31:0]       av_readdata,
    output logic              av_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic [3:0]        ram_be,
    output logic              ram_we,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDATA  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              own_j_q, own_j_d;
    logic              acc_wr_q, acc_wr_d;
    logic              last_j_q, last_j_d;
    logic              j_pend_q, j_pend_d;
    logic              j_wr_q, j_wr_d;
    logic [31:0]       j_wdata_q, j_wdata_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]       ram_wdata_q, ram_wdata_d;
    logic [3:0]        ram_be_q, ram_be_d;
    logic              ram_we_q, ram_we_d;
    logic [31:0]       jtag_rdata_q, jtag_rdata_d;
    logic              ovr_q, ovr_d;

    logic              j_accept_s;
    logic              j_ld_ok_s;
    logic              ovr_set_s;
    logic [ADDR_W-1:0] j_ptr_s;
    logic              j_req_s;
    logic              j_req_wr_s;
    logic [31:0]       j_req_wdata_s;
    logic              av_req_s;
    logic              grant_j_s;
    logic              complete_s;
    logic              j_done_s;
    logic              av_done_s;

    // Request decode; a pending JTAG command blocks any further JTAG command or load.
    always_comb begin
        j_accept_s    = ~j_pend_q & (jtag_rd ^ jtag_wr);
        j_ld_ok_s     = ~j_pend_q & jtag_ld_addr;
        ovr_set_s     = (j_pend_q & (jtag_rd | jtag_wr | jtag_ld_addr)) | (jtag_rd & jtag_wr);
        j_ptr_s       = j_ld_ok_s ? jtag_addr_in : ptr_q;
        j_req_s       = j_pend_q | j_accept_s;
        j_req_wr_s    = j_pend_q ? j_wr_q : jtag_wr;
        j_req_wdata_s = j_pend_q ? j_wdata_q : jtag_wdata;
        av_req_s      = av_read | av_write;
        grant_j_s     = j_req_s & (~av_req_s | ~last_j_q);
        complete_s    = ((state_q == ACCESS) & acc_wr_q) | (state_q == RDATA);
        j_done_s      = complete_s & own_j_q;
        av_done_s     = complete_s & ~own_j_q;
    end

    // Arbitration FSM; RAM controls are staged here so they are registered during ACCESS.
    always_comb begin
        state_d     = state_q;
        own_j_d     = own_j_q;
        acc_wr_d    = acc_wr_q;
        last_j_d    = last_j_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_be_d    = ram_be_q;
        ram_we_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_j_s) begin
                    state_d     = ACCESS;
                    own_j_d     = 1'b1;
                    last_j_d    = 1'b1;
                    acc_wr_d    = j_req_wr_s;
                    ram_addr_d  = j_ptr_s;
                    ram_wdata_d = j_req_wdata_s;
                    ram_be_d    = 4'hF;
                    ram_we_d    = j_req_wr_s;
                end else if (av_req_s) begin
                    state_d     = ACCESS;
                    own_j_d     = 1'b0;
                    last_j_d    = 1'b0;
                    acc_wr_d    = av_write;
                    ram_addr_d  = av_address;
                    ram_wdata_d = av_writedata;
                    ram_be_d    = av_byteenable;
                    ram_we_d    = av_write;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (acc_wr_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = RDATA;
                end
            end
            RDATA: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // JTAG command slot, address pointer, read-result and overrun bookkeeping.
    always_comb begin
        j_pend_d     = j_pend_q;
        j_wr_d       = j_wr_q;
        j_wdata_d    = j_wdata_q;
        ptr_d        = ptr_q;
        jtag_rdata_d = jtag_rdata_q;
        ovr_d        = ovr_q;
        if (j_done_s) begin
            j_pend_d = 1'b0;
            ptr_d    = ptr_q + ADDR_W'(1);
        end else if (j_accept_s) begin
            j_pend_d  = 1'b1;
            j_wr_d    = jtag_wr;
            j_wdata_d = jtag_wdata;
            ptr_d     = j_ptr_s;
        end else if (j_ld_ok_s) begin
            ptr_d = jtag_addr_in;
        end else begin
            ptr_d = ptr_q;
        end
        if (j_done_s && (state_q == RDATA)) begin
            jtag_rdata_d = ram_rdata;
        end else begin
            jtag_rdata_d = jtag_rdata_q;
        end
        if (ovr_set_s) begin
            ovr_d = 1'b1;
        end else if (jtag_clr_overrun) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
    end

    // State and datapath registers; reset abandons any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            own_j_q      <= 1'b0;
            acc_wr_q     <= 1'b0;
            last_j_q     <= 1'b0;
            j_pend_q     <= 1'b0;
            j_wr_q       <= 1'b0;
            j_wdata_q    <= 32'h0;
            ptr_q        <= '0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= 32'h0;
            ram_be_q     <= 4'h0;
            ram_we_q     <= 1'b0;
            jtag_rdata_q <= 32'h0;
            ovr_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            own_j_q      <= own_j_d;
            acc_wr_q     <= acc_wr_d;
            last_j_q     <= last_j_d;
            j_pend_q     <= j_pend_d;
            j_wr_q       <= j_wr_d;
            j_wdata_q    <= j_wdata_d;
            ptr_q        <= ptr_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            ram_be_q     <= ram_be_d;
            ram_we_q     <= ram_we_d;
            jtag_rdata_q <= jtag_rdata_d;
            ovr_q        <= ovr_d;
        end
    end

    assign ram_addr       = ram_addr_q;
    assign ram_wdata      = ram_wdata_q;
    assign ram_be         = ram_be_q;
    assign ram_we         = ram_we_q;
    assign jtag_rdata     = jtag_rdata_q;
    assign jtag_overrun   = ovr_q;
    assign jtag_done      = j_done_s;
    assign av_waitrequest = av_req_s & ~av_done_s;
    // Read data only exists in the RDATA cycle, so it cannot be registered further.
    assign av_readdata    = (av_done_s && (state_q == RDATA)) ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_debug_ocimem_arbiter.sv
// Directed bench for debug_ocimem_arbiter: vector table of single transactions plus
// hand-written tie, overrun and mid-access reset sequences, against a behavioural RAM.
module tb_debug_ocimem_arbiter;

    localparam int K_JWR = 0;
    localparam int K_JRD = 1;
    localparam int K_AWR = 2;
    localparam int K_ARD = 3;

    typedef struct {
        int          kind;
        logic        ld;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [7:0]  exp_addr;
        logic [31:0] exp_data;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        jtag_ld_addr, jtag_rd, jtag_wr, jtag_clr_overrun;
    logic [7:0]  jtag_addr_in;
    logic [31:0] jtag_wdata, jtag_rdata;
    logic        jtag_done, jtag_overrun;
    logic [7:0]  av_address;
    logic        av_read, av_write, av_waitrequest;
    logic [31:0] av_writedata, av_readdata;
    logic [3:0]  av_byteenable;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    logic [3:0]  ram_be;
    logic        ram_we;

    logic [31:0] mem [256];
    int checks = 0;
    int failures = 0;
    vec_t vecs [14];

    debug_ocimem_arbiter #(.ADDR_W(8)) dut (
        .clk(clk), .reset(rst),
        .jtag_ld_addr(jtag_ld_addr), .jtag_addr_in(jtag_addr_in),
        .jtag_rd(jtag_rd), .jtag_wr(jtag_wr), .jtag_wdata(jtag_wdata),
        .jtag_rdata(jtag_rdata), .jtag_done(jtag_done),
        .jtag_overrun(jtag_overrun), .jtag_clr_overrun(jtag_clr_overrun),
        .av_address(av_address), .av_read(av_read), .av_write(av_write),
        .av_writedata(av_writedata), .av_byteenable(av_byteenable),
        .av_readdata(av_readdata), .av_waitrequest(av_waitrequest),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_be(ram_be),
        .ram_we(ram_we), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        end
        return r;
    endfunction

    // Behavioural single-port RAM with one-cycle read latency
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= merge(mem[ram_addr], ram_wdata, ram_be);
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic is_j, is_wr;
        string t;
        is_j  = (v.kind == K_JWR) || (v.kind == K_JRD);
        is_wr = (v.kind == K_JWR) || (v.kind == K_AWR);
        t = $sformatf("vec%0d", idx);
        cyc();
        if (is_j) begin
            jtag_ld_addr = v.ld; jtag_addr_in = v.addr; jtag_wdata = v.wdata;
            jtag_wr = is_wr; jtag_rd = !is_wr;
        end else begin
            av_address = v.addr; av_writedata = v.wdata; av_byteenable = v.be;
            av_write = is_wr; av_read = !is_wr;
        end
        smp();
        chk({t, " wait_req"}, 32'(av_waitrequest), 32'(!is_j));
        chk({t, " done_req"}, 32'(jtag_done), 32'h0);
        cyc();
        jtag_ld_addr = 1'b0; jtag_rd = 1'b0; jtag_wr = 1'b0;
        smp();
        chk({t, " ram_addr"}, 32'(ram_addr), 32'(v.exp_addr));
        chk({t, " ram_we"}, 32'(ram_we), 32'(is_wr));
        if (is_wr) begin
            chk({t, " ram_be"}, 32'(ram_be), is_j ? 32'hF : 32'(v.be));
            chk({t, " ram_wdata"}, ram_wdata, v.wdata);
        end
        chk({t, " done_acc"}, 32'(jtag_done), 32'(is_j && is_wr));
        chk({t, " wait_acc"}, 32'(av_waitrequest), 32'(!is_j && !is_wr));
        cyc();
        if (is_wr) begin
            av_read = 1'b0; av_write = 1'b0;
        end
        smp();
        if (is_wr) begin
            chk({t, " ram_we_after"}, 32'(ram_we), 32'h0);
            chk({t, " done_after"}, 32'(jtag_done), 32'h0);
        end else begin
            chk({t, " done_rdata"}, 32'(jtag_done), 32'(is_j));
            chk({t, " wait_rdata"}, 32'(av_waitrequest), 32'h0);
            if (!is_j) chk({t, " av_readdata"}, av_readdata, v.exp_data);
            cyc();
            av_read = 1'b0; av_write = 1'b0;
            smp();
            chk({t, " done_after"}, 32'(jtag_done), 32'h0);
            if (is_j) chk({t, " jtag_rdata"}, jtag_rdata, v.exp_data);
        end
    endtask

    initial begin
        rst = 1'b1;
        jtag_ld_addr = 1'b0; jtag_rd = 1'b0; jtag_wr = 1'b0; jtag_clr_overrun = 1'b0;
        jtag_addr_in = 8'h00; jtag_wdata = 32'h0;
        av_address = 8'h00; av_read = 1'b0; av_write = 1'b0;
        av_writedata = 32'h0; av_byteenable = 4'h0;

        vecs[0]  = '{K_JWR, 1'b1, 8'h10, 32'hCAFEF00D, 4'hF, 8'h10, 32'h0};
        vecs[1]  = '{K_JWR, 1'b0, 8'h00, 32'h11111111, 4'hF, 8'h11, 32'h0};
        vecs[2]  = '{K_AWR, 1'b0, 8'h05, 32'h12345678, 4'hF, 8'h05, 32'h0};
        vecs[3]  = '{K_ARD, 1'b0, 8'h05, 32'h0,        4'hF, 8'h05, 32'h12345678};
        vecs[4]  = '{K_AWR, 1'b0, 8'h05, 32'hAABBCCDD, 4'h5, 8'h05, 32'h0};
        vecs[5]  = '{K_ARD, 1'b0, 8'h05, 32'h0,        4'hF, 8'h05, 32'h12BB56DD};
        vecs[6]  = '{K_JWR, 1'b1, 8'hFF, 32'hDEADBEEF, 4'hF, 8'hFF, 32'h0};
        vecs[7]  = '{K_JWR, 1'b0, 8'h00, 32'h0BADC0DE, 4'hF, 8'h00, 32'h0};
        vecs[8]  = '{K_JRD, 1'b1, 8'hFF, 32'h0,        4'hF, 8'hFF, 32'hDEADBEEF};
        vecs[9]  = '{K_JRD, 1'b0, 8'h00, 32'h0,        4'hF, 8'h00, 32'h0BADC0DE};
        vecs[10] = '{K_JWR, 1'b0, 8'h00, 32'h01010101, 4'hF, 8'h01, 32'h0};
        vecs[11] = '{K_ARD, 1'b0, 8'h01, 32'h0,        4'hF, 8'h01, 32'h01010101};
        vecs[12] = '{K_JRD, 1'b1, 8'h10, 32'h0,        4'hF, 8'h10, 32'hCAFEF00D};
        vecs[13] = '{K_JRD, 1'b0, 8'h00, 32'h0,        4'hF, 8'h11, 32'h11111111};

        // reset state, including waitrequest following the request while in reset
        cyc(); cyc();
        av_write = 1'b1;
        smp();
        chk("rst wait_req", 32'(av_waitrequest), 32'h1);
        chk("rst ram_addr", 32'(ram_addr), 32'h0);
        chk("rst ram_we", 32'(ram_we), 32'h0);
        chk("rst ram_be", 32'(ram_be), 32'h0);
        chk("rst ram_wdata", ram_wdata, 32'h0);
        chk("rst jtag_rdata", jtag_rdata, 32'h0);
        chk("rst jtag_done", 32'(jtag_done), 32'h0);
        chk("rst overrun", 32'(jtag_overrun), 32'h0);
        chk("rst av_readdata", av_readdata, 32'h0);
        cyc();
        av_write = 1'b0;
        rst = 1'b0;
        smp();
        chk("idle wait", 32'(av_waitrequest), 32'h0);

        for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

        // tie after reset: JTAG first; a fresh JTAG command against waiting Avalon loses
        cyc(); rst = 1'b1;
        cyc(); rst = 1'b0;
        cyc();
        jtag_ld_addr = 1'b1; jtag_addr_in = 8'h10; jtag_rd = 1'b1;
        av_write = 1'b1; av_address = 8'h20; av_writedata = 32'h5A5A5A5A; av_byteenable = 4'hF;
        smp();
        chk("tie1 wait_req", 32'(av_waitrequest), 32'h1);
        cyc();
        jtag_ld_addr = 1'b0; jtag_rd = 1'b0;
        smp();
        chk("tie1 jtag_addr", 32'(ram_addr), 32'h10);
        chk("tie1 av_waits", 32'(av_waitrequest), 32'h1);
        cyc(); smp();
        chk("tie1 jtag_done", 32'(jtag_done), 32'h1);
        chk("tie1 av_still_waits", 32'(av_waitrequest), 32'h1);
        cyc();
        jtag_rd = 1'b1;
        smp();
        chk("tie2 idle_we", 32'(ram_we), 32'h0);
        chk("tie2 idle_done", 32'(jtag_done), 32'h0);
        cyc();
        jtag_rd = 1'b0;
        smp();
        chk("tie2 av_we", 32'(ram_we), 32'h1);
        chk("tie2 av_addr", 32'(ram_addr), 32'h20);
        chk("tie2 av_complete", 32'(av_waitrequest), 32'h0);
        cyc();
        av_write = 1'b0;
        smp();
        chk("tie1 jtag_rdata", jtag_rdata, 32'hCAFEF00D);
        cyc(); smp();
        chk("tie2 jtag_addr", 32'(ram_addr), 32'h11);
        cyc(); smp();
        chk("tie2 jtag_done", 32'(jtag_done), 32'h1);
        cyc(); smp();
        chk("tie2 jtag_rdata", jtag_rdata, 32'h11111111);

        // overrun: command during service is dropped and sticks until cleared
        cyc();
        jtag_ld_addr = 1'b1; jtag_addr_in = 8'h30; jtag_wr = 1'b1; jtag_wdata = 32'h33333333;
        smp();
        chk("ovr initial", 32'(jtag_overrun), 32'h0);
        cyc();
        jtag_ld_addr = 1'b0; jtag_wr = 1'b0; jtag_rd = 1'b1;
        smp();
        chk("ovr wr_done", 32'(jtag_done), 32'h1);
        chk("ovr wr_addr", 32'(ram_addr), 32'h30);
        cyc();
        jtag_rd = 1'b0;
        smp();
        chk("ovr set", 32'(jtag_overrun), 32'h1);
        cyc(); smp();
        chk("ovr dropped_addr", 32'(ram_addr), 32'h30);
        cyc(); smp();
        chk("ovr dropped_done", 32'(jtag_done), 32'h0);
        chk("ovr sticky", 32'(jtag_overrun), 32'h1);
        cyc();
        jtag_clr_overrun = 1'b1;
        smp();
        cyc();
        jtag_clr_overrun = 1'b0;
        smp();
        chk("ovr cleared", 32'(jtag_overrun), 32'h0);
        cyc();
        jtag_rd = 1'b1; jtag_wr = 1'b1; jtag_clr_overrun = 1'b1;
        smp();
        cyc();
        jtag_rd = 1'b0; jtag_wr = 1'b0; jtag_clr_overrun = 1'b0;
        smp();
        chk("ovr rdwr set_wins", 32'(jtag_overrun), 32'h1);
        chk("ovr rdwr ignored", 32'(ram_we), 32'h0);
        chk("ovr rdwr no_done", 32'(jtag_done), 32'h0);
        run_vec('{K_JWR, 1'b0, 8'h00, 32'h31313131, 4'hF, 8'h31, 32'h0}, 100);

        // reset during RDATA of an Avalon read
        cyc();
        av_read = 1'b1; av_address = 8'h05; av_byteenable = 4'hF;
        smp();
        cyc(); smp();
        chk("rstmid access_addr", 32'(ram_addr), 32'h05);
        cyc();
        rst = 1'b1;
        smp();
        chk("rstmid wait_follows_req", 32'(av_waitrequest), 32'h1);
        chk("rstmid av_readdata", av_readdata, 32'h0);
        chk("rstmid ram_addr", 32'(ram_addr), 32'h0);
        chk("rstmid ram_wdata", ram_wdata, 32'h0);
        chk("rstmid ram_be", 32'(ram_be), 32'h0);
        chk("rstmid ram_we", 32'(ram_we), 32'h0);
        chk("rstmid jtag_rdata", jtag_rdata, 32'h0);
        chk("rstmid overrun", 32'(jtag_overrun), 32'h0);
        chk("rstmid jtag_done", 32'(jtag_done), 32'h0);
        cyc();
        av_read = 1'b0;
        cyc();
        rst = 1'b0;
        smp();
        chk("rstmid idle_wait", 32'(av_waitrequest), 32'h0);
        run_vec('{K_JWR, 1'b1, 8'h40, 32'h40404040, 4'hF, 8'h40, 32'h0}, 101);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
